// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_pkg
// Description : Shared definitions for the MCU configuration frame path:
//               opcodes, sequencer state encoding, status bit indices,
//               frame field positions and the frame XOR checksum.
// Revision    : 1.0  initial release
// ============================================================================
package cfg_pkg;

  // Command opcodes carried in frame bits [63:56]
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Sticky status bit indices
  localparam int STAT_CRC_ERR = 0;
  localparam int STAT_BAD_OP  = 1;
  localparam int STAT_RD_TMO  = 2;
  localparam int STAT_OVERRUN = 3;

  // Frame field LSB positions
  localparam int FRM_OP_LSB   = 56;
  localparam int FRM_ADDR_LSB = 48;
  localparam int FRM_DATA_LSB = 16;
  localparam int FRM_RSV_LSB  = 8;
  localparam int FRM_CKS_LSB  = 0;

  // Data returned when a register read never completes
  localparam logic [31:0] RD_TMO_DATA = 32'hDEADBEEF;

  // XOR of frame bytes [63:56] .. [15:8]; the checksum byte itself is ignored
  function automatic logic [7:0] frame_checksum(input logic [63:0] frame);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 1; i < 8; i++) begin
      acc = acc ^ frame[8*i +: 8];
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_xor8.sv
`default_nettype none
// ============================================================================
// Module      : frame_xor8
// Description : Combinational XOR of seven bytes, used to form the frame
//               checksum of a received or outgoing 64-bit frame.
// Ports       : bytes_i  [55:0]  frame bytes [63:8]
//               xor_o    [7:0]   XOR of the seven bytes
// Revision    : 1.0  initial release
// ============================================================================
module frame_xor8 (
  input  logic [55:0] bytes_i,
  output logic [7:0]  xor_o
);

  always_comb begin
    xor_o = 8'h00;
    for (int i = 0; i < 7; i++) begin
      xor_o = xor_o ^ bytes_i[8*i +: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cfg_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cfg_frame_sequencer
// Description : Checks, decodes and executes 64-bit MCU command frames on the
//               configuration register bus and builds the response frame for
//               the next SPI transfer.
// Ports       : CLK, RST            clock, asynchronous active-high reset
//               frame_valid/_data   received frame strobe and contents
//               reg_wr_en/_ready    write request / accept handshake
//               reg_rd_en           one-cycle read strobe
//               reg_rd_valid/_data  read completion
//               reg_addr, reg_wdata register address and write data
//               resp_data/_load     response frame and MISO load strobe
//               busy                state is not IDLE
//               status              sticky status byte (test_LED mirror)
// Revision    : 1.0  initial release
// ============================================================================
module cfg_frame_sequencer
  import cfg_pkg::*;
#(
  parameter int RD_TIMEOUT = 255,
  parameter int ADDR_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              frame_valid,
  input  logic [63:0]       frame_data,
  output logic              reg_wr_en,
  input  logic              reg_wr_ready,
  output logic              reg_rd_en,
  input  logic              reg_rd_valid,
  input  logic [31:0]       reg_rd_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [63:0]       resp_data,
  output logic              resp_load,
  output logic              busy,
  output logic [7:0]        status
);

  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [63:0]       frame_q, frame_d;
  logic [31:0]       data_q,  data_d;
  logic [3:0]        status_q, status_d;
  logic [TMO_W-1:0]  tmo_q,   tmo_d;
  logic              rd_en_q, rd_en_d;

  logic [7:0]        frame_op;
  logic [7:0]        rx_cks;
  logic              crc_ok;
  logic              is_status;
  logic [TMO_W-1:0]  tmo_inc;
  logic [31:0]       resp_word;
  logic [55:0]       resp_body;
  logic [7:0]        resp_cks;

  assign frame_op = frame_q[FRM_OP_LSB +: 8];

  frame_xor8 u_rx_xor (
    .bytes_i (frame_q[63:8]),
    .xor_o   (rx_cks)
  );

  // The latched frame never changes between CHECK and RESP, so the checksum
  // verdict can be recomputed there instead of being stored.
  assign crc_ok    = (rx_cks == frame_q[FRM_CKS_LSB +: 8]);
  assign is_status = crc_ok && (frame_op == OP_STATUS);
  assign tmo_inc   = tmo_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    data_d   = data_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    rd_en_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          frame_d = frame_data;
          data_d  = frame_data[FRM_DATA_LSB +: 32];
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // A bad checksum makes the opcode untrustworthy, so only CRC_ERR is
        // raised in that case.
        if (!crc_ok) begin
          status_d[STAT_CRC_ERR] = 1'b1;
          state_d                = ST_RESP;
        end else begin
          case (frame_op)
            OP_NOP, OP_STATUS: state_d = ST_RESP;
            OP_WRITE:          state_d = ST_WRITE;
            OP_READ: begin
              rd_en_d = 1'b1;
              tmo_d   = '0;
              state_d = ST_READ;
            end
            default: begin
              status_d[STAT_BAD_OP] = 1'b1;
              state_d               = ST_RESP;
            end
          endcase
        end
      end

      ST_WRITE: begin
        if (reg_wr_ready) begin
          state_d = ST_RESP;
        end
      end

      ST_READ: begin
        tmo_d = tmo_inc;
        if (reg_rd_valid) begin
          data_d  = reg_rd_data;
          tmo_d   = '0;
          state_d = ST_RESP;
        end else if (tmo_inc == TMO_W'(RD_TIMEOUT)) begin
          data_d                = RD_TMO_DATA;
          status_d[STAT_RD_TMO] = 1'b1;
          tmo_d                 = '0;
          state_d               = ST_RESP;
        end
      end

      ST_RESP: begin
        if (is_status) begin
          status_d = 4'h0;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Applied after the STATUS clear so an overrun arriving in the RESP
    // cycle is not lost.
    if (frame_valid && (state_q != ST_IDLE)) begin
      status_d[STAT_OVERRUN] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      frame_q  <= 64'h0;
      data_q   <= 32'h0;
      status_q <= 4'h0;
      tmo_q    <= '0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      rd_en_q  <= rd_en_d;
    end
  end

  assign resp_word = is_status ? {24'h0, 4'h0, status_q} : data_q;
  assign resp_body = {frame_q[FRM_OP_LSB +: 8], frame_q[FRM_ADDR_LSB +: 8],
                      resp_word, 4'h0, status_q};

  frame_xor8 u_tx_xor (
    .bytes_i (resp_body),
    .xor_o   (resp_cks)
  );

  assign resp_data = {resp_body, resp_cks};
  assign resp_load = (state_q == ST_RESP);
  assign reg_wr_en = (state_q == ST_WRITE);
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = frame_q[FRM_ADDR_LSB +: ADDR_W];
  assign reg_wdata = frame_q[FRM_DATA_LSB +: 32];
  assign busy      = (state_q != ST_IDLE);
  assign status    = {4'h0, status_q};

endmodule
`default_nettype wire

// File: tb/tb_cfg_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_frame_sequencer
// Description : Self-checking bench for cfg_frame_sequencer: a vector table of
//               single commands plus hand-written overrun and reset sequences,
//               with expected response frames scoreboarded in a queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cfg_frame_sequencer;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        frame_valid = 1'b0;
  logic [63:0] frame_data = 64'h0;
  logic        reg_wr_ready = 1'b0;
  logic        reg_rd_valid = 1'b0;
  logic [31:0] reg_rd_data = 32'h0;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [63:0] resp_data;
  logic        resp_load;
  logic        busy;
  logic [7:0]  status;

  cfg_frame_sequencer #(.RD_TIMEOUT(TMO), .ADDR_W(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_ready (reg_wr_ready),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_valid (reg_rd_valid),
    .reg_rd_data  (reg_rd_data),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .resp_data    (resp_data),
    .resp_load    (resp_load),
    .busy         (busy),
    .status       (status)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] cks(input logic [63:0] f);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < 8; i++) x = x ^ f[8*i +: 8];
    return x;
  endfunction

  function automatic logic [63:0] mk_cmd(input logic [7:0] op, input logic [7:0] addr,
                                         input logic [31:0] data, input logic bad);
    logic [63:0] f;
    f = {op, addr, data, 8'h00, 8'h00};
    f[7:0] = cks(f) ^ {7'b0, bad};
    return f;
  endfunction

  function automatic logic [63:0] mk_resp(input logic [7:0] op, input logic [7:0] addr,
                                          input logic [31:0] data, input logic [7:0] st);
    logic [63:0] f;
    f = {op, addr, data, st, 8'h00};
    f[7:0] = cks(f);
    return f;
  endfunction

  // ---------------- scoreboard / bus monitor ----------------
  typedef struct {
    logic [63:0] resp;
    int          t0;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          resp_cnt     = 0;
  int          wr_cycles    = 0;
  int          wr_bursts    = 0;
  int          rd_cycles    = 0;
  int          wr_field_err = 0;
  logic        wr_prev      = 1'b0;
  logic [7:0]  exp_wr_addr  = 8'h0;
  logic [31:0] exp_wr_data  = 32'h0;

  always @(negedge CLK) begin
    if (reg_wr_en) begin
      wr_cycles++;
      if (!wr_prev) wr_bursts++;
      if (reg_addr !== exp_wr_addr || reg_wdata !== exp_wr_data) wr_field_err++;
    end
    wr_prev = reg_wr_en;
    if (reg_rd_en) rd_cycles++;
    if (resp_load) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp_load: got resp_data %h, expected no response", resp_data);
      end else begin
        cur = sb.pop_front();
        check("resp_data", resp_data, cur.resp);
        check("resp_latency", 64'(cyc - cur.t0), 64'(cur.lat));
      end
    end
  end

  // Drives one command and services the register bus until its response.
  task automatic run_frame(input string name, input logic [63:0] frm, input logic [63:0] exp_resp,
                           input int exp_lat, input int rd_delay, input logic [31:0] rd_val,
                           input int stall, input int ov_k, input int exp_wr, input int exp_rd);
    int   c0, k, r0, w0, b0, rd0, e0;
    exp_t e;
    @(posedge CLK); #1;
    c0 = cyc; r0 = resp_cnt; w0 = wr_cycles; b0 = wr_bursts; rd0 = rd_cycles; e0 = wr_field_err;
    exp_wr_addr = frm[55:48];
    exp_wr_data = frm[47:16];
    e.resp = exp_resp; e.t0 = c0; e.lat = exp_lat;
    sb.push_back(e);
    frame_valid = 1'b1;
    frame_data  = frm;
    reg_rd_data = rd_val;
    k = 0;
    while (resp_cnt == r0 && k < 60) begin
      @(posedge CLK); #1;
      k = cyc - c0;
      frame_valid  = (k == ov_k);
      if (k == ov_k) frame_data = mk_cmd(8'h01, 8'h99, 32'h0BADF00D, 1'b0);
      reg_wr_ready = (k >= 2 + stall);
      reg_rd_valid = (rd_delay >= 0) && (k == 2 + rd_delay);
    end
    frame_valid  = 1'b0;
    reg_wr_ready = 1'b0;
    reg_rd_valid = 1'b0;
    if (resp_cnt == r0) begin
      n_total++;
      $display("FAIL %s.timeout: got no resp_load in 60 cycles, expected one", name);
      void'(sb.pop_back());
    end
    check({name, ".wr_cycles"}, 64'(wr_cycles - w0), 64'(exp_wr));
    check({name, ".wr_bursts"}, 64'(wr_bursts - b0), 64'((exp_wr > 0) ? 1 : 0));
    check({name, ".wr_fields"}, 64'(wr_field_err - e0), 64'(0));
    check({name, ".rd_cycles"}, 64'(rd_cycles - rd0), 64'(exp_rd));
    check({name, ".busy_after"}, 64'(busy), 64'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        bad;
    int          rd_delay;
    logic [31:0] rd_val;
    logic [31:0] exp_data;
    logic [7:0]  exp_st;
    int          lat;
    int          wr;
    int          rd;
  } vec_t;

  vec_t vt[12];

  initial begin
    int c0, r0;
    vt[0]  = '{"write",      8'h01, 8'h10, 32'h12345678, 1'b0, -1, 32'h0,        32'h12345678, 8'h00, 3,  1, 0};
    vt[1]  = '{"read_d3",    8'h02, 8'h20, 32'h00000000, 1'b0,  3, 32'hCAFEF00D, 32'hCAFEF00D, 8'h00, 6,  0, 1};
    vt[2]  = '{"read_d0",    8'h02, 8'h30, 32'h00000000, 1'b0,  0, 32'h11223344, 32'h11223344, 8'h00, 3,  0, 1};
    vt[3]  = '{"nop",        8'h00, 8'h05, 32'hA5A5A5A5, 1'b0, -1, 32'h0,        32'hA5A5A5A5, 8'h00, 2,  0, 0};
    vt[4]  = '{"read_tmo",   8'h02, 8'h40, 32'h00000000, 1'b0, -1, 32'h0,        32'hDEADBEEF, 8'h04, 10, 0, 1};
    vt[5]  = '{"status_tmo", 8'h03, 8'h00, 32'h00000000, 1'b0, -1, 32'h0,        32'h00000004, 8'h04, 2,  0, 0};
    vt[6]  = '{"bad_crc",    8'h01, 8'h50, 32'hDEADC0DE, 1'b1, -1, 32'h0,        32'hDEADC0DE, 8'h01, 2,  0, 0};
    vt[7]  = '{"bad_op",     8'h7F, 8'h60, 32'h00000000, 1'b0, -1, 32'h0,        32'h00000000, 8'h03, 2,  0, 0};
    vt[8]  = '{"status_err", 8'h03, 8'h00, 32'h00000000, 1'b0, -1, 32'h0,        32'h00000003, 8'h03, 2,  0, 0};
    vt[9]  = '{"status_clr", 8'h03, 8'h00, 32'h00000000, 1'b0, -1, 32'h0,        32'h00000000, 8'h00, 2,  0, 0};
    vt[10] = '{"read_last",  8'h02, 8'h41, 32'h00000000, 1'b0,  7, 32'h0F0F0F0F, 32'h0F0F0F0F, 8'h00, 10, 0, 1};
    vt[11] = '{"write_ff",   8'h01, 8'hFF, 32'hFFFFFFFF, 1'b0, -1, 32'h0,        32'hFFFFFFFF, 8'h00, 3,  1, 0};

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", 64'({reg_wr_en, reg_rd_en, resp_load, busy, status, reg_addr, reg_wdata}), 64'(0));
    check("reset_resp_data", resp_data, 64'h0);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_frame(vt[i].name, mk_cmd(vt[i].op, vt[i].addr, vt[i].data, vt[i].bad),
                mk_resp(vt[i].op, vt[i].addr, vt[i].exp_data, vt[i].exp_st),
                vt[i].lat, vt[i].rd_delay, vt[i].rd_val, 0, -1, vt[i].wr, vt[i].rd);
    end

    // second frame arrives during a 5-cycle write stall
    run_frame("overrun_stall", mk_cmd(8'h01, 8'h70, 32'hAABBCCDD, 1'b0),
              mk_resp(8'h01, 8'h70, 32'hAABBCCDD, 8'h08), 8, -1, 32'h0, 5, 3, 6, 0);
    check("overrun_status", 64'(status), 64'(8'h08));
    run_frame("status_ovr", mk_cmd(8'h03, 8'h00, 32'h0, 1'b0),
              mk_resp(8'h03, 8'h00, 32'h00000008, 8'h08), 2, -1, 32'h0, 0, -1, 0, 0);
    check("status_cleared", 64'(status), 64'(0));

    // frame_valid in the same cycle as resp_load
    run_frame("overrun_resp", mk_cmd(8'h00, 8'h01, 32'h01020304, 1'b0),
              mk_resp(8'h00, 8'h01, 32'h01020304, 8'h00), 2, -1, 32'h0, 0, 2, 0, 0);
    check("overrun_resp_status", 64'(status), 64'(8'h08));
    run_frame("status_ovr2", mk_cmd(8'h03, 8'h00, 32'h0, 1'b0),
              mk_resp(8'h03, 8'h00, 32'h00000008, 8'h08), 2, -1, 32'h0, 0, -1, 0, 0);

    // asynchronous reset in the middle of a stalled write
    run_frame("bad_nop", mk_cmd(8'h00, 8'h00, 32'h0, 1'b1),
              mk_resp(8'h00, 8'h00, 32'h0, 8'h01), 2, -1, 32'h0, 0, -1, 0, 0);
    check("status_before_reset", 64'(status), 64'(8'h01));
    @(posedge CLK); #1;
    c0 = cyc; r0 = resp_cnt;
    exp_wr_addr  = 8'h33;
    exp_wr_data  = 32'h55AA55AA;
    reg_wr_ready = 1'b0;
    frame_valid  = 1'b1;
    frame_data   = mk_cmd(8'h01, 8'h33, 32'h55AA55AA, 1'b0);
    @(posedge CLK); #1;
    frame_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("wr_en_before_reset", 64'(reg_wr_en), 64'(1));
    #2 RST = 1'b1;
    #1;
    check("reset_wr_en", 64'(reg_wr_en), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_status", 64'(status), 64'(0));
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    reg_wr_ready = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    reg_wr_ready = 1'b0;
    check("no_resp_after_reset", 64'(resp_cnt - r0), 64'(0));
    check("reset_elapsed", 64'((cyc - c0) > 8), 64'(1));

    run_frame("nop_after_reset", mk_cmd(8'h00, 8'h42, 32'hFEEDFACE, 1'b0),
              mk_resp(8'h00, 8'h42, 32'hFEEDFACE, 8'h00), 2, -1, 32'h0, 0, -1, 0, 0);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
